fp_mul: RTL and testbench

- Pipelined IEEE-754 binary32 multiplier: the PE stage directly upstream of the PE fp32 adder; its product is the adder's PE_a operand.
- Fixed 4-cycle latency, valid-qualified, with a global pipeline enable for systolic stalls.
- Flush-to-zero (FTZ) on denormals; round-to-nearest-even (RNE); canonical NaN on invalid operations.

---
 rtl/fp_pkg.sv | 21 ++
 rtl/fp_classify.sv | 24 ++
 rtl/fp_mul.sv | 202 ++++++++++++++++++++
 tb/tb_fp_mul.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared fp32 types and constants for the PE multiplier and adder.
package fp_pkg;

  localparam int          FP_BIAS    = 127;
  localparam logic [7:0]  FP_EXP_MAX = 8'hFF;
  localparam logic [31:0] QNAN       = 32'h7FC0_0000;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

  typedef enum logic [1:0] {
    FP_ZERO,
    FP_NORM,
    FP_INF,
    FP_NAN
  } fp_class_t;

endpackage

// File: rtl/fp_classify.sv
// Combinational fp32 operand classifier; denormals are reported as zero (FTZ).
module fp_classify (
  input  logic [31:0] op,
  output logic [1:0]  cls
);
  import fp_pkg::*;

  fp32_t     f;
  fp_class_t cls_e;

  assign f = op;

  always_comb begin
    cls_e = FP_NORM;
    if (f.exp == 8'd0) begin
      cls_e = FP_ZERO;
    end else if (f.exp == FP_EXP_MAX) begin
      cls_e = (f.frac == 23'd0) ? FP_INF : FP_NAN;
    end
  end

  assign cls = cls_e;

endmodule

// File: rtl/fp_mul.sv
// Pipelined fp32 multiplier, FTZ + RNE, 4 enabled edges from operand sample to result.
// en=0 freezes every register; bubbles propagate with out_valid and flags low.
module fp_mul #(
  parameter logic [31:0] QNAN = 32'h7FC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        in_valid,
  input  logic [31:0] PE_a,
  input  logic [31:0] PE_b,
  output logic        out_valid,
  output logic [31:0] PE_mult,
  output logic        flag_ovf,
  output logic        flag_unf,
  output logic        flag_inv
);
  import fp_pkg::*;

  // Operand capture: each of S1..S4 then gets a full cycle of its own.
  logic        r0_vld;
  logic [31:0] r0_a, r0_b;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r0_vld <= 1'b0;
      r0_a   <= 32'd0;
      r0_b   <= 32'd0;
    end else if (en) begin
      r0_vld <= in_valid;
      r0_a   <= PE_a;
      r0_b   <= PE_b;
    end
  end

  // S1: unpack / classify
  fp32_t       fa, fb;
  logic [1:0]  cls_a_raw, cls_b_raw;
  fp_class_t   cls_a, cls_b;
  logic        a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
  logic [2:0]  s1_spc_d;
  logic signed [9:0] s1_exp_d;

  assign fa = r0_a;
  assign fb = r0_b;

  fp_classify u_cls_a (.op(r0_a), .cls(cls_a_raw));
  fp_classify u_cls_b (.op(r0_b), .cls(cls_b_raw));

  assign cls_a  = fp_class_t'(cls_a_raw);
  assign cls_b  = fp_class_t'(cls_b_raw);
  assign a_zero = (cls_a == FP_ZERO);
  assign a_inf  = (cls_a == FP_INF);
  assign a_nan  = (cls_a == FP_NAN);
  assign b_zero = (cls_b == FP_ZERO);
  assign b_inf  = (cls_b == FP_INF);
  assign b_nan  = (cls_b == FP_NAN);

  // special vector {nan, inf, zero}, resolved by priority in S4
  assign s1_spc_d = {a_nan | b_nan | (a_zero & b_inf) | (a_inf & b_zero),
                     a_inf | b_inf,
                     a_zero | b_zero};
  assign s1_exp_d = $signed({2'b00, fa.exp}) + $signed({2'b00, fb.exp}) - 10'sd127;

  logic        s1_vld, s1_sign;
  logic signed [9:0] s1_exp;
  logic [23:0] s1_ma, s1_mb;
  logic [2:0]  s1_spc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_vld  <= 1'b0;
      s1_sign <= 1'b0;
      s1_exp  <= 10'sd0;
      s1_ma   <= 24'd0;
      s1_mb   <= 24'd0;
      s1_spc  <= 3'd0;
    end else if (en) begin
      s1_vld  <= r0_vld;
      s1_sign <= fa.sign ^ fb.sign;
      s1_exp  <= s1_exp_d;
      s1_ma   <= {1'b1, fa.frac};
      s1_mb   <= {1'b1, fb.frac};
      s1_spc  <= s1_spc_d;
    end
  end

  // S2: 24x24 mantissa product
  logic        s2_vld, s2_sign;
  logic signed [9:0] s2_exp;
  logic [47:0] s2_prod;
  logic [2:0]  s2_spc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_vld  <= 1'b0;
      s2_sign <= 1'b0;
      s2_exp  <= 10'sd0;
      s2_prod <= 48'd0;
      s2_spc  <= 3'd0;
    end else if (en) begin
      s2_vld  <= s1_vld;
      s2_sign <= s1_sign;
      s2_exp  <= s1_exp;
      s2_prod <= {24'd0, s1_ma} * {24'd0, s1_mb};
      s2_spc  <= s1_spc;
    end
  end

  // S3: normalize the product in [1,4) to 24 bits plus guard/sticky
  logic [23:0] s3_mant_d;
  logic        s3_g_d, s3_s_d;
  logic signed [9:0] s3_exp_d;

  always_comb begin
    s3_mant_d = s2_prod[46:23];
    s3_g_d    = s2_prod[22];
    s3_s_d    = |s2_prod[21:0];
    s3_exp_d  = s2_exp;
    if (s2_prod[47]) begin
      s3_mant_d = s2_prod[47:24];
      s3_g_d    = s2_prod[23];
      s3_s_d    = |s2_prod[22:0];
      s3_exp_d  = s2_exp + 10'sd1;
    end
  end

  logic        s3_vld, s3_sign, s3_g, s3_s;
  logic signed [9:0] s3_exp;
  logic [23:0] s3_mant;
  logic [2:0]  s3_spc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s3_vld  <= 1'b0;
      s3_sign <= 1'b0;
      s3_exp  <= 10'sd0;
      s3_mant <= 24'd0;
      s3_g    <= 1'b0;
      s3_s    <= 1'b0;
      s3_spc  <= 3'd0;
    end else if (en) begin
      s3_vld  <= s2_vld;
      s3_sign <= s2_sign;
      s3_exp  <= s3_exp_d;
      s3_mant <= s3_mant_d;
      s3_g    <= s3_g_d;
      s3_s    <= s3_s_d;
      s3_spc  <= s2_spc;
    end
  end

  // S4: RNE round, range check, special override
  logic        round_up;
  logic [24:0] rnd;
  logic signed [9:0] s4_exp;
  logic [31:0] s4_res;
  logic        s4_ovf, s4_unf, s4_inv;

  assign round_up = s3_g & (s3_s | s3_mant[0]);
  assign rnd      = {1'b0, s3_mant} + {24'd0, round_up};
  // on carry-out rnd[22:0] is already zero, i.e. the mantissa is 1.0
  assign s4_exp   = s3_exp + $signed({9'd0, rnd[24]});

  always_comb begin
    s4_res = {s3_sign, s4_exp[7:0], rnd[22:0]};
    s4_ovf = 1'b0;
    s4_unf = 1'b0;
    s4_inv = 1'b0;
    if (s3_spc[2]) begin
      s4_res = QNAN;
      s4_inv = 1'b1;
    end else if (s3_spc[1]) begin
      s4_res = {s3_sign, FP_EXP_MAX, 23'd0};
    end else if (s3_spc[0]) begin
      s4_res = {s3_sign, 31'd0};
    end else if (s4_exp >= 10'sd255) begin
      s4_res = {s3_sign, FP_EXP_MAX, 23'd0};
      s4_ovf = 1'b1;
    end else if (s4_exp <= 10'sd0) begin
      s4_res = {s3_sign, 31'd0};
      s4_unf = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      PE_mult   <= 32'd0;
      flag_ovf  <= 1'b0;
      flag_unf  <= 1'b0;
      flag_inv  <= 1'b0;
    end else if (en) begin
      out_valid <= s3_vld;
      PE_mult   <= s4_res;
      flag_ovf  <= s4_ovf & s3_vld;
      flag_unf  <= s4_unf & s3_vld;
      flag_inv  <= s4_inv & s3_vld;
    end
  end

endmodule

// File: tb/tb_fp_mul.sv
// Randomized + directed bench for fp_mul against an exact-integer fp32 reference model.
module tb_fp_mul;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        in_valid;
  logic [31:0] PE_a, PE_b;
  logic        out_valid;
  logic [31:0] PE_mult;
  logic        flag_ovf, flag_unf, flag_inv;

  fp_mul dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid),
    .PE_a(PE_a), .PE_b(PE_b),
    .out_valid(out_valid), .PE_mult(PE_mult),
    .flag_ovf(flag_ovf), .flag_unf(flag_unf), .flag_inv(flag_inv)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        vld;
    bit [31:0] res;
    bit [2:0]  flg;   // {ovf, unf, inv}
  } exp_t;

  exp_t pipe[5];
  exp_t nxt;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", tag, got, want, $time);
    end
  endtask

  // Exact product via 64-bit integers, explicit RNE on the remainder, FTZ on range.
  function automatic exp_t ref_mul(input bit [31:0] a, input bit [31:0] b);
    exp_t   r;
    bit     sgn, an, ai, az, bn, bi, bz;
    int     ea, eb, k, drop, e;
    longint ma, mb, m, q, rem, half;
    r.vld = 1'b1;
    r.flg = 3'b000;
    sgn = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    an = (ea == 255) && (a[22:0] != 0);
    ai = (ea == 255) && (a[22:0] == 0);
    az = (ea == 0);
    bn = (eb == 255) && (b[22:0] != 0);
    bi = (eb == 255) && (b[22:0] == 0);
    bz = (eb == 0);
    if (an || bn || (az && bi) || (ai && bz)) begin
      r.res = 32'h7FC0_0000;
      r.flg = 3'b001;
    end else if (ai || bi) begin
      r.res = {sgn, 8'hFF, 23'd0};
    end else if (az || bz) begin
      r.res = {sgn, 31'd0};
    end else begin
      ma = (longint'(1) << 23) | longint'(a[22:0]);
      mb = (longint'(1) << 23) | longint'(b[22:0]);
      m  = ma * mb;
      k  = 0;
      for (int i = 0; i < 48; i++) if (m[i]) k = i;
      drop = k - 23;
      q    = m >> drop;
      rem  = m - (q << drop);
      half = longint'(1) << (drop - 1);
      if (rem > half || (rem == half && q[0])) q++;
      if (q == (longint'(1) << 24)) begin
        q = q >> 1;
        drop++;
      end
      // value = q * 2^(drop + ea + eb - 300), q in [2^23, 2^24)
      e = ea + eb + drop - 150;
      if (e >= 255) begin
        r.res = {sgn, 8'hFF, 23'd0};
        r.flg = 3'b100;
      end else if (e <= 0) begin
        r.res = {sgn, 31'd0};
        r.flg = 3'b010;
      end else begin
        r.res = {sgn, e[7:0], q[22:0]};
      end
    end
    return r;
  endfunction

  task automatic drive(input bit v, input bit [31:0] a, input bit [31:0] b);
    in_valid = v;
    PE_a     = a;
    PE_b     = b;
    if (v) nxt = ref_mul(a, b);
    else   nxt = '{vld: 1'b0, res: 32'd0, flg: 3'b000};
  endtask

  task automatic drive_want(input bit [31:0] a, input bit [31:0] b,
                            input bit [31:0] want, input bit [2:0] flg);
    in_valid = 1'b1;
    PE_a     = a;
    PE_b     = b;
    nxt      = '{vld: 1'b1, res: want, flg: flg};
  endtask

  task automatic clear_pipe();
    for (int i = 0; i < 5; i++) pipe[i] = '{vld: 1'b0, res: 32'd0, flg: 3'b000};
  endtask

  task automatic compare();
    chk("out_valid", {31'd0, out_valid}, {31'd0, pipe[4].vld});
    if (pipe[4].vld) begin
      chk("product", PE_mult, pipe[4].res);
      chk("flags", {29'd0, flag_ovf, flag_unf, flag_inv}, {29'd0, pipe[4].flg});
    end else begin
      chk("bubble_flags", {29'd0, flag_ovf, flag_unf, flag_inv}, 32'd0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) begin
      clear_pipe();
    end else if (en) begin
      for (int i = 4; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = nxt;
    end
    #1;
    compare();
  endtask

  function automatic bit [31:0] rnd_op();
    bit [7:0]  e;
    bit [31:0] f;
    case ($urandom_range(0, 9))
      0:       e = 8'h00;
      1:       e = 8'hFF;
      2:       e = 8'($urandom_range(1, 30));
      3:       e = 8'($urandom_range(225, 254));
      4:       e = 8'($urandom_range(100, 150));
      default: e = 8'($urandom_range(1, 254));
    endcase
    f = $urandom;
    if ($urandom_range(0, 7) == 0) f = 32'd0;
    return {1'($urandom_range(0, 1)), e, f[22:0]};
  endfunction

  localparam int ND = 11;
  bit [31:0] dv_a [ND] = '{32'h4000_0000, 32'h3FC0_0000, 32'h3F80_0001, 32'hC000_0000,
                           32'h7F00_0000, 32'h0080_0000, 32'h8000_0001, 32'h0000_0000,
                           32'h7FA0_0000, 32'hFF80_0000, 32'h3F80_0000};
  bit [31:0] dv_b [ND] = '{32'h4040_0000, 32'h3FC0_0000, 32'h3F80_0001, 32'h3F00_0000,
                           32'h4000_0000, 32'h3F00_0000, 32'h4000_0000, 32'h7F80_0000,
                           32'h3F80_0000, 32'h4000_0000, 32'h3F80_0000};
  bit [31:0] dv_r [ND] = '{32'h40C0_0000, 32'h4010_0000, 32'h3F80_0002, 32'hBF80_0000,
                           32'h7F80_0000, 32'h0000_0000, 32'h8000_0000, 32'h7FC0_0000,
                           32'h7FC0_0000, 32'hFF80_0000, 32'h3F80_0000};
  bit [2:0]  dv_f [ND] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b100, 3'b010,
                           3'b000, 3'b001, 3'b001, 3'b000, 3'b000};

  initial begin
    rst = 1'b0;
    en  = 1'b0;
    clear_pipe();
    drive(1'b0, 32'd0, 32'd0);
    #2;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_mult", PE_mult, 32'd0);
    chk("rst_flags", {29'd0, flag_ovf, flag_unf, flag_inv}, 32'd0);
    step();
    step();
    rst = 1'b1;
    en  = 1'b1;
    step();

    // single op: exact 4-edge latency with a one-cycle valid pulse
    drive_want(dv_a[0], dv_b[0], dv_r[0], dv_f[0]);
    step();
    drive(1'b0, 32'd0, 32'd0);
    repeat (6) step();

    // back-to-back directed table
    for (int i = 1; i < ND; i++) begin
      drive_want(dv_a[i], dv_b[i], dv_r[i], dv_f[i]);
      step();
    end
    drive(1'b0, 32'd0, 32'd0);
    repeat (6) step();

    // stall: two enabled issues, two frozen edges with junk offered, third issue
    drive_want(32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 3'b000);
    step();
    drive_want(32'h4040_0000, 32'h4040_0000, 32'h4110_0000, 3'b000);
    step();
    en = 1'b0;
    drive(1'b1, 32'h7F80_0000, 32'h0000_0000);
    nxt = '{vld: 1'b0, res: 32'd0, flg: 3'b000};
    step();
    step();
    en = 1'b1;
    drive_want(32'hBF80_0000, 32'h4080_0000, 32'hC080_0000, 3'b000);
    step();
    drive(1'b0, 32'd0, 32'd0);
    repeat (6) step();

    // reset with three ops in flight
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, rnd_op(), rnd_op());
      step();
    end
    drive(1'b0, 32'd0, 32'd0);
    rst = 1'b0;
    #2;
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_mult", PE_mult, 32'd0);
    clear_pipe();
    step();
    step();
    rst = 1'b1;
    repeat (5) step();
    drive_want(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 3'b000);
    step();
    drive(1'b0, 32'd0, 32'd0);
    repeat (6) step();

    // randomized traffic with random stalls and bubbles
    for (int n = 0; n < 600; n++) begin
      en = ($urandom_range(0, 7) != 0);
      drive($urandom_range(0, 3) != 0, rnd_op(), rnd_op());
      step();
    end
    en = 1'b1;
    drive(1'b0, 32'd0, 32'd0);
    repeat (6) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
